// File: rtl/vga_pixel_gen_if.sv
// Pixel-stream bundle between the VGA timing stage and the pixel generator,
// plus read-only visibility of the bouncing-square state.
interface vga_pixel_gen_if;
   logic       p_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync_in;
   logic       vsync_in;
   logic       pause;
   logic [2:0] bg_color;
   logic [2:0] rgb;
   logic       hsync;
   logic       vsync;
   logic [9:0] sq_x_o;
   logic [9:0] sq_y_o;
   logic       dir_x_o;
   logic       dir_y_o;

   // Stream contract: inputs are qualified by p_tick (no back-pressure);
   // rgb/hsync/vsync load only on p_tick edges, one pixel after their inputs.
   modport master (
      output p_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, pause, bg_color,
      input  rgb, hsync, vsync, sq_x_o, sq_y_o, dir_x_o, dir_y_o
   );

   modport slave (
      input  p_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in, pause, bg_color,
      output rgb, hsync, vsync, sq_x_o, sq_y_o, dir_x_o, dir_y_o
   );
endinterface

// File: rtl/vga_pixel_gen.sv
// Bouncing red square between two blue wall bands over a live background
// colour; colour and syncs are registered together for one pixel of latency.
module vga_pixel_gen #(
   parameter int SQ_SIZE = 16,
   parameter int VEL     = 2,
   parameter int WALL    = 8
) (
   input logic           clk_50M,
   input logic           rst_n,
   vga_pixel_gen_if.slave vga
);

   localparam logic [10:0] VEL_W   = 11'(VEL);
   localparam logic [10:0] SQ_W    = 11'(SQ_SIZE);
   localparam logic [10:0] X_MIN   = 11'(WALL);
   localparam logic [10:0] X_MAX   = 11'(640 - WALL - SQ_SIZE);
   localparam logic [10:0] Y_MAX   = 11'(480 - SQ_SIZE);
   localparam logic [10:0] WALL_HI = 11'(640 - WALL);

   logic [9:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
   logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [2:0] rgb_q, rgb_d;
   logic       hsync_q, vsync_q;

   logic [10:0] sq_x_w, sq_y_w, px_w, py_w;
   logic        frame_tick, sq_on, wall_on;

   assign sq_x_w = {1'b0, sq_x_q};
   assign sq_y_w = {1'b0, sq_y_q};
   assign px_w   = {1'b0, vga.pixel_x};
   assign py_w   = {1'b0, vga.pixel_y};

   // Row 480 lies in vertical blanking, so a move never tears a visible frame.
   assign frame_tick = vga.p_tick && (vga.pixel_x == 10'd0) && (vga.pixel_y == 10'd480);

   always_comb begin
      sq_x_d  = sq_x_q;
      dir_x_d = dir_x_q;
      sq_y_d  = sq_y_q;
      dir_y_d = dir_y_q;
      if (frame_tick && !vga.pause) begin
         if (dir_x_q) begin
            if (sq_x_w + VEL_W >= X_MAX) begin
               sq_x_d  = X_MAX[9:0];
               dir_x_d = 1'b0;
            end else begin
               sq_x_d = sq_x_q + VEL_W[9:0];
            end
         end else begin
            if (sq_x_w <= X_MIN + VEL_W) begin
               sq_x_d  = X_MIN[9:0];
               dir_x_d = 1'b1;
            end else begin
               sq_x_d = sq_x_q - VEL_W[9:0];
            end
         end
         if (dir_y_q) begin
            if (sq_y_w + VEL_W >= Y_MAX) begin
               sq_y_d  = Y_MAX[9:0];
               dir_y_d = 1'b0;
            end else begin
               sq_y_d = sq_y_q + VEL_W[9:0];
            end
         end else begin
            if (sq_y_w <= VEL_W) begin
               sq_y_d  = 10'd0;
               dir_y_d = 1'b1;
            end else begin
               sq_y_d = sq_y_q - VEL_W[9:0];
            end
         end
      end
   end

   assign sq_on   = (px_w >= sq_x_w) && (px_w < sq_x_w + SQ_W) &&
                    (py_w >= sq_y_w) && (py_w < sq_y_w + SQ_W);
   assign wall_on = (px_w < X_MIN) || (px_w >= WALL_HI);

   always_comb begin
      rgb_d = vga.bg_color;
      if (!vga.video_on) rgb_d = 3'b000;
      else if (sq_on)    rgb_d = 3'b100;
      else if (wall_on)  rgb_d = 3'b001;
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         sq_x_q  <= 10'd312;
         sq_y_q  <= 10'd232;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         rgb_q   <= 3'b000;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         sq_x_q  <= sq_x_d;
         sq_y_q  <= sq_y_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
         if (vga.p_tick) begin
            rgb_q   <= rgb_d;
            hsync_q <= vga.hsync_in;
            vsync_q <= vga.vsync_in;
         end
      end
   end

   assign vga.rgb     = rgb_q;
   assign vga.hsync   = hsync_q;
   assign vga.vsync   = vsync_q;
   assign vga.sq_x_o  = sq_x_q;
   assign vga.sq_y_o  = sq_y_q;
   assign vga.dir_x_o = dir_x_q;
   assign vga.dir_y_o = dir_y_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: pixel classification, bounce motion,
// pause behaviour, sync alignment and asynchronous reset.
module tb_vga_pixel_gen;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b1;

   vga_pixel_gen_if vga ();

   vga_pixel_gen dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .vga     (vga.slave)
   );

   always #10 clk_50M = ~clk_50M;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] exp_q[$];

   // Reference model of the square
   int   mx, my;
   logic mdx, mdy;

   task automatic model_reset();
      mx = 312; my = 232; mdx = 1'b1; mdy = 1'b1;
   endtask

   task automatic model_step();
      if (mdx) begin
         if (mx + 2 >= 616) begin mx = 616; mdx = 1'b0; end
         else mx = mx + 2;
      end else begin
         if (mx <= 10) begin mx = 8; mdx = 1'b1; end
         else mx = mx - 2;
      end
      if (mdy) begin
         if (my + 2 >= 464) begin my = 464; mdy = 1'b0; end
         else my = my + 2;
      end else begin
         if (my <= 2) begin my = 0; mdy = 1'b1; end
         else my = my - 2;
      end
   endtask

   function automatic logic [2:0] exp_rgb(int x, int y, logic von, logic [2:0] bg);
      if (!von) return 3'b000;
      if (x >= mx && x < mx + 16 && y >= my && y < my + 16) return 3'b100;
      if (x < 8 || x >= 632) return 3'b001;
      return bg;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag);
      chk({tag, ".sq_x"},  32'(vga.sq_x_o),  32'(mx));
      chk({tag, ".sq_y"},  32'(vga.sq_y_o),  32'(my));
      chk({tag, ".dir_x"}, 32'(vga.dir_x_o), 32'(mdx));
      chk({tag, ".dir_y"}, 32'(vga.dir_y_o), 32'(mdy));
   endtask

   // One pixel period: tick cycle carries the pixel, the idle cycle carries
   // deliberately different inputs that must not reach the outputs.
   task automatic pix(input int x, input int y, input logic von,
                      input logic hs, input logic vs, input logic pz);
      logic [4:0] e;
      @(negedge clk_50M);
      vga.p_tick   = 1'b1;
      vga.pixel_x  = 10'(x);
      vga.pixel_y  = 10'(y);
      vga.video_on = von;
      vga.hsync_in = hs;
      vga.vsync_in = vs;
      vga.pause    = pz;
      exp_q.push_back({exp_rgb(x, y, von, vga.bg_color), hs, vs});
      @(posedge clk_50M); #1;
      e = exp_q.pop_front();
      chk("pix_out", 32'({vga.rgb, vga.hsync, vga.vsync}), 32'(e));
      @(negedge clk_50M);
      vga.p_tick   = 1'b0;
      vga.pixel_x  = 10'd0;
      vga.pixel_y  = 10'd480;
      vga.video_on = ~von;
      vga.hsync_in = ~hs;
      vga.vsync_in = ~vs;
      vga.pause    = ~pz;
      @(posedge clk_50M); #1;
      chk("idle_hold", 32'({vga.rgb, vga.hsync, vga.vsync}), 32'(e));
   endtask

   task automatic frame(input logic pz, input string tag);
      pix(0, 480, 1'b0, 1'b0, 1'b1, pz);
      if (!pz) model_step();
      chk_pos(tag);
   endtask

   initial begin
      vga.p_tick   = 1'b0;
      vga.pixel_x  = 10'd0;
      vga.pixel_y  = 10'd0;
      vga.video_on = 1'b0;
      vga.hsync_in = 1'b0;
      vga.vsync_in = 1'b0;
      vga.pause    = 1'b0;
      vga.bg_color = 3'b010;
      model_reset();

      // Reset applied between clock edges
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rgb",   32'(vga.rgb),   32'd0);
      chk("rst_hsync", 32'(vga.hsync), 32'd0);
      chk("rst_vsync", 32'(vga.vsync), 32'd0);
      chk_pos("rst");
      repeat (3) @(posedge clk_50M);
      @(negedge clk_50M) rst_n = 1'b1;

      // Classification at reset position
      pix(312, 232, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(0,   100, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(320, 10,  1'b1, 1'b0, 1'b0, 1'b0);
      vga.bg_color = 3'b011;
      pix(400, 300, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(327, 247, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(328, 232, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(312, 248, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(311, 240, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(7,   50,  1'b1, 1'b0, 1'b0, 1'b0);
      pix(8,   50,  1'b1, 1'b0, 1'b0, 1'b0);
      pix(631, 50,  1'b1, 1'b0, 1'b0, 1'b0);
      pix(632, 50,  1'b1, 1'b0, 1'b0, 1'b0);
      pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(320, 240, 1'b0, 1'b0, 1'b0, 1'b0);

      // Motion: 1 frame then 3 more
      frame(1'b0, "f1");
      chk("f1_x", 32'(vga.sq_x_o), 32'd314);
      chk("f1_y", 32'(vga.sq_y_o), 32'd234);
      repeat (3) frame(1'b0, "f");
      chk("f4_x", 32'(vga.sq_x_o), 32'd320);
      chk("f4_y", 32'(vga.sq_y_o), 32'd240);
      pix(320, 240, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(319, 240, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(335, 255, 1'b1, 1'b0, 1'b0, 1'b0);

      // Pause holds across frames; pause level at the tick edge decides
      repeat (5) frame(1'b1, "pause");
      chk("pause_x", 32'(vga.sq_x_o), 32'd320);
      frame(1'b0, "pause_release");

      // Long run through all four wall/edge bounces
      for (int i = 0; i < 520; i++) begin
         frame(1'b0, "run");
         if (i % 97 == 0) pix(mx + 3, my + 5, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Sync pulse: 96 pixel periods high, aligned one pixel behind input
      for (int i = 0; i < 4; i++)  pix(656 + i, 10, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 96; i++) pix(660 + i, 10, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)  pix(756 + i, 10, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

      // Asynchronous reset mid-frame with square on screen
      pix(mx, my, 1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk_50M);
      #5 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_rgb",   32'(vga.rgb),   32'd0);
      chk("midrst_hsync", 32'(vga.hsync), 32'd0);
      chk("midrst_vsync", 32'(vga.vsync), 32'd0);
      chk_pos("midrst");
      @(negedge clk_50M) rst_n = 1'b1;
      pix(312, 232, 1'b1, 1'b0, 1'b0, 1'b0);
      frame(1'b0, "post_rst");

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
